lsu_mem_adapter: RTL

LSU_MEM_ADAPTER -- requirements
Module: lsu_mem_adapter

---
 rtl/lsu_mem_adapter_if.sv | 40 ++++
 rtl/lsu_mem_adapter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_adapter_if.sv
// rtl/lsu_mem_adapter_if.sv - request/response and memory-port bundle for lsu_mem_adapter
//
// Signals:
//   req_valid_i / req_ready_o   request handshake (pipeline -> adapter)
//   req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i  request fields
//   resp_valid_o, resp_rdata_o, misalign_o                        one-cycle response
//   mem_we_o, mem_addr_o, mem_wdata_o, mem_rdata_i                word memory port
// Modports:
//   slave  - the adapter
//   master - the pipeline plus memory environment driving the adapter
interface lsu_mem_adapter_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic        misalign_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    modport slave (
        input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        input  mem_rdata_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, misalign_o,
        output mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        output mem_rdata_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, misalign_o,
        input  mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/lsu_mem_adapter.sv
// rtl/lsu_mem_adapter.sv - load/store unit to word-wide memory adapter with sub-word merge
//
// Ports:
//   clk_i   clock, all state on rising edge
//   rst_ni  asynchronous active-low reset
//   bus     lsu_mem_adapter_if.slave: request handshake, one-cycle response,
//           word memory port (combinational read, write on falling edge)
// Build option:
//   LSU_MISALIGN_CHECK_EN  when defined, misaligned half/word requests skip memory and
//                          respond with misalign_o=1; otherwise the low address bits
//                          are truncated to natural alignment.
module lsu_mem_adapter (
    input  logic               clk_i,
    input  logic               rst_ni,
    lsu_mem_adapter_if.slave   bus
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MERGE, S_STORE, S_RESP} state_t;

    state_t      state_q, state_d;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] merge_q;
    logic [31:0] rdata_q;

    logic        req_mis;
    logic        accept;
    logic [1:0]  lane;
    logic [31:0] shifted;
    logic [31:0] load_val;
    logic [3:0]  byte_en;
    logic [31:0] rep;
    logic [31:0] merged;

    assign accept = (state_q == S_IDLE) && bus.req_valid_i;

`ifdef LSU_MISALIGN_CHECK_EN
    logic mis_q;
    assign req_mis = ((bus.req_size_i == 2'b01) && bus.req_addr_i[0]) ||
                     (bus.req_size_i[1] && (bus.req_addr_i[1:0] != 2'b00));
    assign bus.misalign_o = mis_q && (state_q == S_RESP);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mis_q <= 1'b0;
        end else if (accept) begin
            mis_q <= req_mis;
        end
    end
`else
    assign req_mis        = 1'b0;
    assign bus.misalign_o = 1'b0;
`endif

    assign bus.mem_addr_o   = {addr_q[31:2], 2'b00};
    assign bus.mem_wdata_o  = merge_q;
    assign bus.resp_rdata_o = rdata_q;

    // Lane masked to natural alignment: only matters when misaligned accesses proceed.
    always_comb begin
        lane    = 2'b00;
        byte_en = 4'b1111;
        rep     = wdata_q;
        case (size_q)
            2'b00: begin
                lane    = addr_q[1:0];
                byte_en = 4'b0001 << lane;
                rep     = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                lane    = {addr_q[1], 1'b0};
                byte_en = 4'b0011 << lane;
                rep     = {2{wdata_q[15:0]}};
            end
            default: begin
                lane    = 2'b00;
                byte_en = 4'b1111;
                rep     = wdata_q;
            end
        endcase
    end

    always_comb begin
        shifted  = bus.mem_rdata_i >> {lane, 3'b000};
        load_val = shifted;
        case (size_q)
            2'b00:   load_val = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
            default: load_val = shifted;
        endcase
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = byte_en[i] ? rep[8*i +: 8] : bus.mem_rdata_i[8*i +: 8];
        end
    end

    always_comb begin
        state_d          = state_q;
        bus.req_ready_o  = 1'b0;
        bus.resp_valid_o = 1'b0;
        bus.mem_we_o     = 1'b0;
        case (state_q)
            S_IDLE: begin
                bus.req_ready_o = 1'b1;
                if (bus.req_valid_i) begin
                    if (req_mis)              state_d = S_RESP;
                    else if (!bus.req_we_i)   state_d = S_LOAD;
                    else if (bus.req_size_i[1]) state_d = S_STORE;
                    else                      state_d = S_MERGE;
                end
            end
            S_LOAD:  state_d = S_RESP;
            S_MERGE: state_d = S_STORE;
            S_STORE: begin
                // Decoded from the async-reset state, so reset drops the write at once.
                bus.mem_we_o = 1'b1;
                state_d      = S_RESP;
            end
            S_RESP: begin
                bus.resp_valid_o = 1'b1;
                state_d          = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            merge_q <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= bus.req_we_i;
                size_q  <= bus.req_size_i;
                uns_q   <= bus.req_unsigned_i;
                addr_q  <= bus.req_addr_i;
                wdata_q <= bus.req_wdata_i;
                // Word stores bypass MERGE, so the store data goes straight to the write register.
                if (bus.req_we_i && bus.req_size_i[1] && !req_mis) begin
                    merge_q <= bus.req_wdata_i;
                end
            end
            if (state_q == S_LOAD) begin
                rdata_q <= load_val;
            end
            if (state_q == S_MERGE) begin
                merge_q <= merged;
            end
        end
    end

    logic unused_we;
    assign unused_we = we_q;
endmodule
